// File: rtl/yuv_split_pkg.sv
// Shared types and constants for the YUYV 4:2:2 to planar 4:2:0 splitter.
// Holds the capture FSM encoding, the byte-phase encoding and a width helper.
// No logic of its own.
package yuv_split_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Position of a byte inside one YUYV macropixel
    localparam logic [1:0] PH_Y0 = 2'd0;
    localparam logic [1:0] PH_U  = 2'd1;
    localparam logic [1:0] PH_Y1 = 2'd2;
    localparam logic [1:0] PH_V  = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/yuv_plane_fifo.sv
// Synchronous show-ahead FIFO for one pixel plane (DEPTH must be a power of 2, >= 2).
// Latency: a push is visible on dout with empty=0 the following cycle.
// Backpressure: push while full is discarded (full is sampled before any same-cycle pop).
module yuv_plane_fifo
    import yuv_split_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush & ~reset;
    assign do_pop  = pop & ~empty & ~flush & ~reset;

    // Gate the head so an empty FIFO presents zero rather than stale storage
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/yuv422_to_420_splitter.sv
// Splits a YUYV 4:2:2 camera byte stream into Y/U/V planar FIFOs, chroma kept on even lines only (4:2:0).
// Latency: an accepted byte appears on its plane head one cycle later; optional YUV_SPLIT_OVF_CNT_EN adds ovf_count.
// Backpressure: none toward the camera; bytes hitting a full FIFO are dropped and flagged in overflow.
module yuv422_to_420_splitter
    import yuv_split_pkg::*;
#(
    parameter int FRAME_W      = 640,
    parameter int FRAME_H      = 480,
    parameter int Y_FIFO_DEPTH = 64,
    parameter int C_FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_en,
    input  logic        ctrl_clear,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_valid,
    input  logic [7:0]  cam_data,
    output logic [7:0]  y_data_z,
    output logic        y_data_vz,
    input  logic        y_data_lz,
    output logic [7:0]  u_data_z,
    output logic        u_data_vz,
    input  logic        u_data_lz,
    output logic [7:0]  v_data_z,
    output logic        v_data_vz,
    input  logic        v_data_lz,
    output logic        frame_done,
    output logic        frame_short,
    output logic        overflow
`ifdef YUV_SPLIT_OVF_CNT_EN
    ,
    output logic [15:0] ovf_count
`endif
);

    localparam int BW = clog2(2 * FRAME_W + 1);
    localparam int LW = (clog2(FRAME_H + 1) < 1) ? 1 : clog2(FRAME_H + 1);
    localparam logic [BW-1:0] LINE_BYTES = BW'(2 * FRAME_W);
    localparam logic [LW-1:0] LAST_LINE  = LW'(FRAME_H - 1);

    state_t        state;
    logic          vsync_q;
    logic          href_q;
    logic [1:0]    phase;
    logic [BW-1:0] byte_cnt;
    logic [LW-1:0] line_cnt;

    logic          vs_fall, vs_rise, href_rise, href_fall;
    logic [1:0]    cur_phase;
    logic [BW-1:0] cur_bcnt;
    logic          accept;
    logic          even_line;
    logic          y_push, u_push, v_push;
    logic          y_full, u_full, v_full;
    logic          y_empty, u_empty, v_empty;
    logic          drop;

    assign vs_fall   = vsync_q & ~cam_vsync;
    assign vs_rise   = ~vsync_q & cam_vsync;
    assign href_rise = ~href_q & cam_href;
    assign href_fall = href_q & ~cam_href;

    // The first byte of a line may arrive in the same cycle href rises
    assign cur_phase = href_rise ? PH_Y0 : phase;
    assign cur_bcnt  = href_rise ? '0 : byte_cnt;

    assign accept    = (state == ACTIVE) & cam_href & cam_valid & (cur_bcnt < LINE_BYTES) & ~ctrl_clear;
    assign even_line = ~line_cnt[0];

    assign y_push = accept & ((cur_phase == PH_Y0) | (cur_phase == PH_Y1));
    assign u_push = accept & even_line & (cur_phase == PH_U);
    assign v_push = accept & even_line & (cur_phase == PH_V);
    assign drop   = (y_push & y_full) | (u_push & u_full) | (v_push & v_full);

    assign y_data_vz = ~y_empty;
    assign u_data_vz = ~u_empty;
    assign v_data_vz = ~v_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ctrl_clear) begin
            state       <= IDLE;
            phase       <= PH_Y0;
            byte_cnt    <= '0;
            line_cnt    <= '0;
            frame_done  <= 1'b0;
            frame_short <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                phase    <= cur_phase + 2'd1;
                byte_cnt <= cur_bcnt + 1'b1;
            end else if (href_rise) begin
                phase    <= PH_Y0;
                byte_cnt <= '0;
            end

            if (drop) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (ctrl_en) state <= WAIT_VS;
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        state       <= ACTIVE;
                        line_cnt    <= '0;
                        frame_done  <= 1'b0;
                        frame_short <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // A completed last line wins over a coincident vsync rise
                    if (href_fall) begin
                        line_cnt <= line_cnt + 1'b1;
                        if (line_cnt == LAST_LINE) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end
                    end else if (vs_rise) begin
                        state       <= DONE;
                        frame_done  <= 1'b1;
                        frame_short <= 1'b1;
                    end
                end
                DONE: begin
                    state <= ctrl_en ? WAIT_VS : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef YUV_SPLIT_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || ctrl_clear) begin
            ovf_count <= '0;
        end else if (drop && (ovf_count != 16'hFFFF)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

    yuv_plane_fifo #(.DEPTH(Y_FIFO_DEPTH), .W(8)) u_y_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (ctrl_clear),
        .push  (y_push),
        .din   (cam_data),
        .pop   (y_data_lz),
        .dout  (y_data_z),
        .full  (y_full),
        .empty (y_empty)
    );

    yuv_plane_fifo #(.DEPTH(C_FIFO_DEPTH), .W(8)) u_u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (ctrl_clear),
        .push  (u_push),
        .din   (cam_data),
        .pop   (u_data_lz),
        .dout  (u_data_z),
        .full  (u_full),
        .empty (u_empty)
    );

    yuv_plane_fifo #(.DEPTH(C_FIFO_DEPTH), .W(8)) u_v_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (ctrl_clear),
        .push  (v_push),
        .din   (cam_data),
        .pop   (v_data_lz),
        .dout  (v_data_z),
        .full  (v_full),
        .empty (v_empty)
    );

endmodule

// File: tb/tb_yuv422_to_420_splitter.sv
// Directed bench: nominal frame, handshake drain, overflow (second instance with a 4-deep Y FIFO),
// short frame, mid-line clear and an over-long line.
module tb_yuv422_to_420_splitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ctrl_en, ctrl_clear, cam_vsync, cam_href, cam_valid;
    logic [7:0] cam_data;

    logic [7:0] y_z, u_z, v_z;
    logic       y_vz, u_vz, v_vz, y_lz, u_lz, v_lz;
    logic       frame_done, frame_short, overflow;

    logic [7:0] b_y_z, b_u_z, b_v_z;
    logic       b_y_vz, b_u_vz, b_v_vz, b_y_lz;
    logic       b_frame_done, b_frame_short, b_overflow;

`ifdef YUV_SPLIT_OVF_CNT_EN
    logic [15:0] ovf_count, b_ovf_count;
`endif

    yuv422_to_420_splitter #(.FRAME_W(4), .FRAME_H(2), .Y_FIFO_DEPTH(8), .C_FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ctrl_en(ctrl_en), .ctrl_clear(ctrl_clear),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_valid(cam_valid), .cam_data(cam_data),
        .y_data_z(y_z), .y_data_vz(y_vz), .y_data_lz(y_lz),
        .u_data_z(u_z), .u_data_vz(u_vz), .u_data_lz(u_lz),
        .v_data_z(v_z), .v_data_vz(v_vz), .v_data_lz(v_lz),
        .frame_done(frame_done), .frame_short(frame_short), .overflow(overflow)
`ifdef YUV_SPLIT_OVF_CNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    yuv422_to_420_splitter #(.FRAME_W(4), .FRAME_H(2), .Y_FIFO_DEPTH(4), .C_FIFO_DEPTH(4)) dut_ovf (
        .clk(clk), .reset(reset), .ctrl_en(ctrl_en), .ctrl_clear(ctrl_clear),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_valid(cam_valid), .cam_data(cam_data),
        .y_data_z(b_y_z), .y_data_vz(b_y_vz), .y_data_lz(b_y_lz),
        .u_data_z(b_u_z), .u_data_vz(b_u_vz), .u_data_lz(1'b0),
        .v_data_z(b_v_z), .v_data_vz(b_v_vz), .v_data_lz(1'b0),
        .frame_done(b_frame_done), .frame_short(b_frame_short), .overflow(b_overflow)
`ifdef YUV_SPLIT_OVF_CNT_EN
        , .ovf_count(b_ovf_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         plane;
        logic [7:0] dat;
        logic       vz_after;
    } pop_vec_t;

    pop_vec_t   pv [12];
    logic [7:0] lb [10];
    logic [7:0] line0 [10];
    logic [7:0] line1 [10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_vz(input int p);
        case (p)
            0:       return y_vz;
            1:       return u_vz;
            default: return v_vz;
        endcase
    endfunction

    function automatic logic [7:0] get_z(input int p);
        case (p)
            0:       return y_z;
            1:       return u_z;
            default: return v_z;
        endcase
    endfunction

    task automatic pop_plane(input int p);
        case (p)
            0:       y_lz = 1'b1;
            1:       u_lz = 1'b1;
            default: v_lz = 1'b1;
        endcase
        tick();
        y_lz = 1'b0;
        u_lz = 1'b0;
        v_lz = 1'b0;
    endtask

    task automatic send_line(input int n);
        cam_href = 1'b1;
        for (int i = 0; i < n; i++) begin
            cam_valid = 1'b1;
            cam_data  = lb[i];
            tick();
        end
        cam_href  = 1'b0;
        cam_valid = 1'b0;
        cam_data  = 8'd0;
        tick();
        tick();
    endtask

    task automatic start_frame();
        ctrl_en = 1'b1;
        tick();
        ctrl_en = 1'b0;
        tick();
        cam_vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic end_frame();
        cam_vsync = 1'b1;
        tick();
        tick();
    endtask

    task automatic run_full_frame(input int len0);
        start_frame();
        for (int i = 0; i < 10; i++) lb[i] = line0[i];
        send_line(len0);
        for (int i = 0; i < 10; i++) lb[i] = line1[i];
        send_line(8);
        end_frame();
    endtask

    task automatic run_drain(input string tag);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_vz_before[%0d]", tag, i), 16'(get_vz(pv[i].plane)), 16'd1);
            check($sformatf("%s_data[%0d]", tag, i), 16'(get_z(pv[i].plane)), 16'(pv[i].dat));
            pop_plane(pv[i].plane);
            check($sformatf("%s_vz_after[%0d]", tag, i), 16'(get_vz(pv[i].plane)), 16'(pv[i].vz_after));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        line0 = '{8'd10, 8'd20, 8'd11, 8'd30, 8'd12, 8'd21, 8'd13, 8'd31, 8'd99, 8'd98};
        line1 = '{8'd14, 8'd22, 8'd15, 8'd32, 8'd16, 8'd23, 8'd17, 8'd33, 8'd0, 8'd0};
        pv = '{
            '{0, 8'd10, 1'b1}, '{0, 8'd11, 1'b1}, '{0, 8'd12, 1'b1}, '{0, 8'd13, 1'b1},
            '{0, 8'd14, 1'b1}, '{0, 8'd15, 1'b1}, '{0, 8'd16, 1'b1}, '{0, 8'd17, 1'b0},
            '{1, 8'd20, 1'b1}, '{1, 8'd21, 1'b0},
            '{2, 8'd30, 1'b1}, '{2, 8'd31, 1'b0}
        };

        reset = 1'b1; ctrl_en = 1'b0; ctrl_clear = 1'b0;
        cam_vsync = 1'b1; cam_href = 1'b0; cam_valid = 1'b0; cam_data = 8'd0;
        y_lz = 1'b0; u_lz = 1'b0; v_lz = 1'b0; b_y_lz = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_y_vz", 16'(y_vz), 16'd0);
        check("rst_u_vz", 16'(u_vz), 16'd0);
        check("rst_v_vz", 16'(v_vz), 16'd0);
        check("rst_y_z", 16'(y_z), 16'd0);
        check("rst_frame_done", 16'(frame_done), 16'd0);
        check("rst_frame_short", 16'(frame_short), 16'd0);
        check("rst_overflow", 16'(overflow), 16'd0);
`ifdef YUV_SPLIT_OVF_CNT_EN
        check("rst_ovf_count", ovf_count, 16'd0);
`endif

        // Nominal frame with all pops held off until the frame ends
        run_full_frame(8);
        check("nom_frame_done", 16'(frame_done), 16'd1);
        check("nom_frame_short", 16'(frame_short), 16'd0);
        check("nom_overflow", 16'(overflow), 16'd0);
        check("nom_y_head", 16'(y_z), 16'd10);
        check("ovf_flag", 16'(b_overflow), 16'd1);
`ifdef YUV_SPLIT_OVF_CNT_EN
        check("ovf_count", b_ovf_count, 16'd4);
`endif
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_y_vz[%0d]", i), 16'(b_y_vz), 16'd1);
            check($sformatf("ovf_y_data[%0d]", i), 16'(b_y_z), 16'(8'd10 + 8'(i)));
            b_y_lz = 1'b1;
            tick();
            b_y_lz = 1'b0;
        end
        check("ovf_y_empty", 16'(b_y_vz), 16'd0);

        run_drain("nom");
        pop_plane(0);
        check("pop_on_empty_y_vz", 16'(y_vz), 16'd0);
        check("pop_on_empty_u_vz", 16'(u_vz), 16'd0);

        // Clear wipes the sticky flags of both instances
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
        check("clr_frame_done", 16'(frame_done), 16'd0);
        check("clr_b_overflow", 16'(b_overflow), 16'd0);
`ifdef YUV_SPLIT_OVF_CNT_EN
        check("clr_ovf_count", b_ovf_count, 16'd0);
`endif

        // Short frame: vsync rises after line 0
        start_frame();
        for (int i = 0; i < 10; i++) lb[i] = line0[i];
        send_line(8);
        end_frame();
        check("short_frame_done", 16'(frame_done), 16'd1);
        check("short_frame_short", 16'(frame_short), 16'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("short_y_data[%0d]", i), 16'(y_z), 16'(8'd10 + 8'(i)));
            pop_plane(0);
        end
        check("short_y_empty", 16'(y_vz), 16'd0);
        for (int i = 8; i < 12; i++) begin
            check($sformatf("short_c_data[%0d]", i), 16'(get_z(pv[i].plane)), 16'(pv[i].dat));
            pop_plane(pv[i].plane);
            check($sformatf("short_c_vz[%0d]", i), 16'(get_vz(pv[i].plane)), 16'(pv[i].vz_after));
        end

        // Clear after three bytes of line 0; the rest of the frame must be ignored
        start_frame();
        cam_href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cam_valid = 1'b1;
            cam_data  = line0[i];
            tick();
        end
        check("mid_y_vz_pre", 16'(y_vz), 16'd1);
        check("mid_u_vz_pre", 16'(u_vz), 16'd1);
        cam_data   = line0[3];
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
        check("mid_y_vz", 16'(y_vz), 16'd0);
        check("mid_u_vz", 16'(u_vz), 16'd0);
        check("mid_v_vz", 16'(v_vz), 16'd0);
        check("mid_frame_done", 16'(frame_done), 16'd0);
        check("mid_frame_short", 16'(frame_short), 16'd0);
        for (int i = 4; i < 8; i++) begin
            cam_valid = 1'b1;
            cam_data  = line0[i];
            tick();
        end
        cam_href = 1'b0; cam_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) lb[i] = line1[i];
        send_line(8);
        end_frame();
        check("mid_post_y_vz", 16'(y_vz), 16'd0);
        check("mid_post_v_vz", 16'(v_vz), 16'd0);
        check("mid_post_done", 16'(frame_done), 16'd0);

        // Over-long first line: bytes 9 and 10 must be ignored
        run_full_frame(10);
        check("long_frame_done", 16'(frame_done), 16'd1);
        check("long_frame_short", 16'(frame_short), 16'd0);
        check("long_overflow", 16'(overflow), 16'd0);
        run_drain("long");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
